// File: rtl/seq_fsm_detect_sched.sv
//------------------------------------------------------------------------------
// Module      : seq_fsm_detect_sched
// Description : One Mealy sequence detector shared between two requesters.
//               A round-robin arbiter grants one requester per cycle. The
//               detector runs on that requester's saved 2-bit context, and
//               the result comes out registered one cycle later, tagged with
//               the owner's index.
//               Optional: define SEQ_FSM_SCHED_CNT_EN to add the per-requester
//               saturating counters cnt0/cnt1 of out=1 results.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_fsm_detect_sched #(
   parameter int NREQ = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_val,
   input  logic       req1_val,
   input  logic       req0_in,
   input  logic       req1_in,
   output logic       req0_rdy,
   output logic       req1_rdy,
   input  logic       clr0,
   input  logic       clr1,
   output logic [1:0] state0,
   output logic [1:0] state1,
   output logic       out_val,
   output logic       out,
   output logic       out_id
`ifdef SEQ_FSM_SCHED_CNT_EN
   ,
   output logic [7:0] cnt0,
   output logic [7:0] cnt1
`endif
);

   localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] ST_A = 2'd0;
   localparam logic [1:0] ST_B = 2'd1;
   localparam logic [1:0] ST_C = 2'd2;
   localparam logic [1:0] ST_D = 2'd3;

   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [1:0]      state0_q, state0_d;
   logic [1:0]      state1_q, state1_d;
   logic            out_val_q, out_val_d;
   logic            out_q, out_d;
   logic            out_id_q, out_id_d;

   logic            gnt0, gnt1, xfer;
   logic [1:0]      cur_state, det_next;
   logic            cur_in, det_out;

   // Round-robin grant: lone requester wins, a tie goes to the pointer; nothing during reset
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (req0_val && (!req1_val || ptr_q == '0)) begin
            gnt0 = 1'b1;
         end else if (req1_val && (!req0_val || ptr_q != '0)) begin
            gnt1 = 1'b1;
         end
      end
   end

   assign xfer      = gnt0 | gnt1;
   assign req0_rdy  = gnt0;
   assign req1_rdy  = gnt1;
   assign cur_state = gnt1 ? state1_q : state0_q;
   assign cur_in    = gnt1 ? req1_in  : req0_in;

   // Shared Mealy detector evaluated on the granted requester's context
   always_comb begin
      det_next = ST_A;
      det_out  = 1'b0;
      case (cur_state)
         ST_A: begin det_next = cur_in ? ST_B : ST_A; det_out =  cur_in; end
         ST_B: begin det_next = cur_in ? ST_B : ST_C; det_out = ~cur_in; end
         ST_C: begin det_next = cur_in ? ST_D : ST_A; det_out =  cur_in; end
         ST_D: begin det_next = cur_in ? ST_B : ST_C; det_out =  1'b0;   end
         default: begin det_next = ST_A; det_out = 1'b0; end
      endcase
   end

   // Next-state for contexts, pointer and result; clear beats a same-cycle transfer
   always_comb begin
      state0_d  = state0_q;
      state1_d  = state1_q;
      ptr_d     = ptr_q;
      out_val_d = xfer;
      out_d     = out_q;
      out_id_d  = out_id_q;
      if (clr0) begin
         state0_d = ST_A;
      end else if (gnt0) begin
         state0_d = det_next;
      end
      if (clr1) begin
         state1_d = ST_A;
      end else if (gnt1) begin
         state1_d = det_next;
      end
      if (xfer) begin
         // Pointer moves to the requester that did not just transfer
         ptr_d    = ID_W'(gnt0);
         out_d    = det_out;
         out_id_d = gnt1;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q     <= '0;
         state0_q  <= ST_A;
         state1_q  <= ST_A;
         out_val_q <= 1'b0;
         out_q     <= 1'b0;
         out_id_q  <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         state0_q  <= state0_d;
         state1_q  <= state1_d;
         out_val_q <= out_val_d;
         out_q     <= out_d;
         out_id_q  <= out_id_d;
      end
   end

   assign state0  = state0_q;
   assign state1  = state1_q;
   assign out_val = out_val_q;
   assign out     = out_q;
   assign out_id  = out_id_q;

`ifdef SEQ_FSM_SCHED_CNT_EN
   logic [7:0] cnt0_q, cnt0_d;
   logic [7:0] cnt1_q, cnt1_d;

   // Saturating count of out=1 results per requester; clear has priority
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (clr0) begin
         cnt0_d = 8'd0;
      end else if (gnt0 && det_out && cnt0_q != 8'hFF) begin
         cnt0_d = cnt0_q + 8'd1;
      end
      if (clr1) begin
         cnt1_d = 8'd0;
      end else if (gnt1 && det_out && cnt1_q != 8'hFF) begin
         cnt1_d = cnt1_q + 8'd1;
      end
   end

   // Counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0_q <= 8'd0;
         cnt1_q <= 8'd0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_fsm_detect_sched.sv
//------------------------------------------------------------------------------
// Module      : tb_seq_fsm_detect_sched
// Description : Self-checking bench for seq_fsm_detect_sched. A table-driven
//               reference model tracks the contexts, pointer and results, and
//               is compared against the DUT every cycle. Directed scenarios
//               also pin hand-computed values. SEQ_FSM_SCHED_CNT_EN enables
//               the counter checks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_fsm_detect_sched;

   logic clk = 1'b0;
   logic reset, req0_val, req1_val, req0_in, req1_in, clr0, clr1;
   logic req0_rdy, req1_rdy, out_val, out, out_id;
   logic [1:0] state0, state1;
`ifdef SEQ_FSM_SCHED_CNT_EN
   logic [7:0] cnt0, cnt1;
`endif

   always #5 clk = ~clk;

   seq_fsm_detect_sched #(.NREQ(2)) dut (
      .clk(clk), .reset(reset),
      .req0_val(req0_val), .req1_val(req1_val),
      .req0_in(req0_in), .req1_in(req1_in),
      .req0_rdy(req0_rdy), .req1_rdy(req1_rdy),
      .clr0(clr0), .clr1(clr1),
      .state0(state0), .state1(state1),
      .out_val(out_val), .out(out), .out_id(out_id)
`ifdef SEQ_FSM_SCHED_CNT_EN
      , .cnt0(cnt0), .cnt1(cnt1)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Transition/output tables indexed [state][in], A=0 B=1 C=2 D=3
   int NXT  [4][2] = '{'{0, 1}, '{2, 1}, '{0, 3}, '{2, 1}};
   int MOUT [4][2] = '{'{0, 1}, '{1, 0}, '{0, 1}, '{0, 0}};

   int m_st [2];
   int m_cnt[2];
   int m_ptr = 0, m_ov = 0, m_o = 0, m_oid = 0;
   bit m_live = 1'b0;

   // Who gets the detector: lone valid wins, both valid -> pointer, none -> -1
   function automatic int pick(input bit v0, input bit v1, input int p);
      if (v0 && !v1) return 0;
      if (v1 && !v0) return 1;
      if (v0 && v1)  return p;
      return -1;
   endfunction

   // Reference model: advances on each rising edge from the sampled inputs
   always @(posedge clk) begin : model
      int g, b, res;
      if (reset) begin
         m_st[0] = 0; m_st[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
         m_ptr = 0; m_ov = 0; m_o = 0; m_oid = 0;
         m_live = 1'b1;
      end else begin
         g = pick(req0_val, req1_val, m_ptr);
         if (g >= 0) begin
            b     = (g == 1) ? int'(req1_in) : int'(req0_in);
            res   = MOUT[m_st[g]][b];
            m_ov  = 1; m_o = res; m_oid = g;
            m_st[g] = NXT[m_st[g]][b];
            m_ptr = 1 - g;
            if (res == 1 && m_cnt[g] < 255) m_cnt[g]++;
         end else begin
            m_ov = 0;
         end
         if (clr0) begin m_st[0] = 0; m_cnt[0] = 0; end
         if (clr1) begin m_st[1] = 0; m_cnt[1] = 0; end
      end
   end

   // Compare process: every falling edge, once the model has seen a reset
   always @(negedge clk) begin : compare
      int g;
      if (m_live) begin
         g = reset ? -1 : pick(req0_val, req1_val, m_ptr);
         chk("cmp_rdy0", int'(req0_rdy), (g == 0) ? 1 : 0);
         chk("cmp_rdy1", int'(req1_rdy), (g == 1) ? 1 : 0);
         chk("cmp_out_val", int'(out_val), m_ov);
         chk("cmp_out", int'(out), m_o);
         chk("cmp_out_id", int'(out_id), m_oid);
         chk("cmp_state0", int'(state0), m_st[0]);
         chk("cmp_state1", int'(state1), m_st[1]);
`ifdef SEQ_FSM_SCHED_CNT_EN
         chk("cmp_cnt0", int'(cnt0), m_cnt[0]);
         chk("cmp_cnt1", int'(cnt1), m_cnt[1]);
`endif
      end
   end

   task automatic drive(input bit r, input bit v0, input bit i0, input bit v1,
                        input bit i1, input bit c0, input bit c1);
      reset = r; req0_val = v0; req0_in = i0; req1_val = v1; req1_in = i1;
      clr0 = c0; clr1 = c1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      drive(1, 0, 0, 0, 0, 0, 0);
      tick;
   endtask

   initial begin : stim
      int b27 [4] = '{1, 0, 1, 1};
      int o27 [4] = '{1, 1, 1, 0};
      int s27 [4] = '{1, 2, 3, 1};

      drive(1, 1, 1, 1, 1, 0, 0);
      #1;
      chk("rst_rdy0", int'(req0_rdy), 0);
      chk("rst_rdy1", int'(req1_rdy), 0);
      tick;
      tick;
      chk("rst_out_val", int'(out_val), 0);
      chk("rst_out", int'(out), 0);
      chk("rst_state0", int'(state0), 0);
      chk("rst_state1", int'(state1), 0);

      // Requester 0 alone: 1,0,1,1
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, b27[k][0], 0, 0, 0, 0);
         tick;
         chk("r0_alone_val", int'(out_val), 1);
         chk("r0_alone_out", int'(out), o27[k]);
         chk("r0_alone_id", int'(out_id), 0);
         chk("r0_alone_st", int'(state0), s27[k]);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      tick;
      chk("idle_val", int'(out_val), 0);
      chk("idle_out_hold", int'(out), 0);

      // Both valid every cycle: grants alternate starting with requester 0
      do_reset;
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, 1, 1, 0, 0, 0);
         #1;
         chk("rr_rdy1", int'(req1_rdy), k % 2);
         chk("rr_rdy0", int'(req0_rdy), 1 - (k % 2));
         tick;
         chk("rr_out_id", int'(out_id), k % 2);
      end

      // Interleave req0:1, req1:0, req0:0
      do_reset;
      drive(0, 1, 1, 0, 0, 0, 0); tick;
      chk("il_a_out", int'(out), 1); chk("il_a_id", int'(out_id), 0);
      drive(0, 0, 0, 1, 0, 0, 0); tick;
      chk("il_b_out", int'(out), 0); chk("il_b_id", int'(out_id), 1);
      drive(0, 1, 0, 0, 0, 0, 0); tick;
      chk("il_c_out", int'(out), 1); chk("il_c_id", int'(out_id), 0);
      chk("il_state1", int'(state1), 0);
      chk("il_state0", int'(state0), 2);

      // Clear while in D with a transfer of 0: result from D, context back to A
      do_reset;
      drive(0, 1, 1, 0, 0, 0, 0); tick;
      drive(0, 1, 0, 0, 0, 0, 0); tick;
      drive(0, 1, 1, 0, 0, 0, 0); tick;
      chk("clr_pre_d", int'(state0), 3);
      drive(0, 1, 0, 0, 0, 1, 0); tick;
      chk("clr_val", int'(out_val), 1);
      chk("clr_out", int'(out), 0);
      chk("clr_state0", int'(state0), 0);

      // Reset in mid-stream
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0, 0);
         tick;
      end
      drive(1, 1, 1, 1, 1, 0, 0);
      #1;
      chk("mrst_rdy0", int'(req0_rdy), 0);
      chk("mrst_rdy1", int'(req1_rdy), 0);
      tick;
      chk("mrst_val", int'(out_val), 0);
      chk("mrst_st0", int'(state0), 0);
      chk("mrst_st1", int'(state1), 0);
`ifdef SEQ_FSM_SCHED_CNT_EN
      chk("mrst_cnt0", int'(cnt0), 0);
      chk("mrst_cnt1", int'(cnt1), 0);
`endif
      drive(0, 1, 0, 1, 0, 0, 0);
      #1;
      chk("mrst_ptr0", int'(req0_rdy), 1);
      tick;

`ifdef SEQ_FSM_SCHED_CNT_EN
      // 300 ones alternating with zeros on requester 0 -> saturation
      do_reset;
      for (int k = 0; k < 300; k++) begin
         drive(0, 1, 1, 0, 0, 0, 0); tick;
         drive(0, 1, 0, 0, 0, 0, 0); tick;
      end
      chk("sat_cnt0", int'(cnt0), 255);
      chk("sat_cnt1", int'(cnt1), 0);
      drive(0, 1, 1, 0, 0, 1, 0); tick;
      chk("sat_clr_cnt0", int'(cnt0), 0);
`endif

      // Mixed traffic with occasional clears and resets
      for (int k = 0; k < 300; k++) begin
         drive(1'($urandom_range(0, 31) == 0),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
         tick;
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      tick;
      tick;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
